// File: rtl/uart_rxd_receiver.sv
// Purpose : 8N1 serial receiver (8E1 when RX_PARITY_EN is defined) with oversampling
//           and 3-sample majority voting; each good byte is flagged by a one-clk strobe.
// Latency : strobe issued at mid-stop-bit, about 9.5 bit periods plus 2-3 clk after the start edge.
// Backpressure: none. The byte is held on RxD_data until the next good frame overwrites it.
//
// Build option: `define RX_PARITY_EN selects 8E1 framing and adds the RxD_parity_err port.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   rst            synchronous reset, active-high
//   RxD            asynchronous serial line, idle high
//   RxD_data       last good received byte
//   RxD_data_ready one-cycle strobe, RxD_data valid
//   RxD_frame_err  one-cycle strobe, stop bit sampled low
//   RxD_busy       high from start-bit detection until the frame completes or is aborted
//   RxD_parity_err one-cycle strobe, even-parity mismatch (RX_PARITY_EN only)
module uart_rxd_receiver #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16          // must be >= 8 and even
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_frame_err,
    output logic       RxD_busy
`ifdef RX_PARITY_EN
    ,
    output logic       RxD_parity_err
`endif
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_W   = $clog2(OVERSAMPLE);
    localparam int SMID  = OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizer; resets to the idle (high) line level.
    // ------------------------------------------------------------------
    logic rxd_meta_q;
    logic rxd_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= RxD;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,   state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [S_W-1:0]     s_q,       s_d;
    logic [1:0]         samp_q,    samp_d;
    logic [7:0]         shift_q,   shift_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         data_q,    data_d;
    logic               ready_q,   ready_d;
    logic               ferr_q,    ferr_d;
    logic               armed_q,   armed_d;
`ifdef RX_PARITY_EN
    logic               par_q,     par_d;
    logic               perr_q,    perr_d;
`endif

    logic tick;
    logic samp_a;
    logic samp_b;
    logic decide;
    logic bit_end;
    logic maj;

    // Sample ticks only run inside a frame; the divider is held at zero in
    // IDLE so bit timing is phased to the detected start edge.
    assign tick    = (state_q != ST_IDLE) && (div_cnt_q == DIV_W'(DIV - 1));
    assign samp_a  = tick && (s_q == S_W'(SMID - 1));
    assign samp_b  = tick && (s_q == S_W'(SMID));
    assign decide  = tick && (s_q == S_W'(SMID + 1));
    assign bit_end = tick && (s_q == S_W'(OVERSAMPLE - 1));

    // The third vote is the live synchronized line at the decision tick.
    assign maj = (samp_q[0] & samp_q[1]) |
                 (samp_q[0] & rxd_sync_q) |
                 (samp_q[1] & rxd_sync_q);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        s_d       = s_q;
        samp_d    = samp_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        ferr_d    = 1'b0;
        armed_d   = 1'b0;
`ifdef RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif

        // Tick divider and per-bit sample counter
        if (state_q == ST_IDLE) begin
            div_cnt_d = '0;
            s_d       = '0;
        end else begin
            if (div_cnt_q == DIV_W'(DIV - 1)) begin
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
            if (tick) begin
                if (s_q == S_W'(OVERSAMPLE - 1)) begin
                    s_d = '0;
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
        end

        if (samp_a) begin
            samp_d[0] = rxd_sync_q;
        end
        if (samp_b) begin
            samp_d[1] = rxd_sync_q;
        end

        case (state_q)
            ST_IDLE: begin
                // armed_q remembers the line was high last cycle, so only a
                // real high-to-low edge starts a frame (a held break does not).
                armed_d   = rxd_sync_q;
                bit_cnt_d = '0;
                if (armed_q && !rxd_sync_q) begin
                    state_d = ST_START;
                    armed_d = 1'b0;
                end
            end

            ST_START: begin
                if (decide && maj) begin
                    state_d = ST_IDLE;          // glitch, not a start bit
                end else if (bit_end) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (decide) begin
                    shift_d = {maj, shift_q[7:1]};
                end
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end

`ifdef RX_PARITY_EN
            ST_PARITY: begin
                if (decide) begin
                    par_d = maj;
                end
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                // Leave at mid-stop-bit so a directly following start bit
                // is caught by IDLE edge detection.
                if (decide) begin
                    state_d = ST_IDLE;
                    if (!maj) begin
                        ferr_d = 1'b1;
`ifdef RX_PARITY_EN
                    end else if ((^shift_q) != par_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            s_q       <= '0;
            samp_q    <= 2'b11;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            data_q    <= 8'h00;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
            armed_q   <= 1'b0;
`ifdef RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            s_q       <= s_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
            armed_q   <= armed_d;
`ifdef RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign RxD_data       = data_q;
    assign RxD_data_ready = ready_q;
    assign RxD_frame_err  = ferr_q;
    assign RxD_busy       = (state_q != ST_IDLE);
`ifdef RX_PARITY_EN
    assign RxD_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rxd_receiver.sv
// Purpose : scoreboard bench for uart_rxd_receiver; frames are driven at the true line
//           baud rate and the expected strobe for each frame is queued for a monitor.
// Latency : expected strobe about 9.5 receiver bit periods after the start edge.
// Backpressure: none; the monitor pops one expectation per observed strobe.
module tb_uart_rxd_receiver;

    localparam int CLK_FREQ = 50000000;
    localparam int BAUD     = 115200;
    localparam int OS       = 16;
    localparam int BIT_CLK  = CLK_FREQ / BAUD;              // line bit period in clk
    localparam int RX_BIT   = (CLK_FREQ / (BAUD * OS)) * OS; // receiver bit period in clk
`ifdef RX_PARITY_EN
    localparam int BITS_BEFORE_STOP = 10;
`else
    localparam int BITS_BEFORE_STOP = 9;
`endif
    // Strobe lands mid-stop-bit; allow for the voting samples trailing mid-bit,
    // the synchronizer delay and one divider period of phase slop.
    localparam int LAT_NOM = BITS_BEFORE_STOP * RX_BIT + RX_BIT / 2;
    localparam int LAT_MIN = LAT_NOM - RX_BIT / OS;
    localparam int LAT_MAX = LAT_NOM + 3 * (RX_BIT / OS) + 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_frame_err;
    logic       RxD_busy;
    logic       perr;

    uart_rxd_receiver #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .RxD            (RxD),
        .RxD_data       (RxD_data),
        .RxD_data_ready (RxD_data_ready),
        .RxD_frame_err  (RxD_frame_err),
        .RxD_busy       (RxD_busy)
`ifdef RX_PARITY_EN
        ,
        .RxD_parity_err (perr)
`endif
    );

`ifndef RX_PARITY_EN
    assign perr = 1'b0;
`endif

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_READY = 0, EV_FERR = 1, EV_PERR = 2} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
        int         t0;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame starting now; caller sits #1 after a rising edge.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        ev_t e;
        e.data = b;
        e.t0   = cyc;
        if (!stop_ok)      e.kind = EV_FERR;
`ifdef RX_PARITY_EN
        else if (!par_ok)  e.kind = EV_PERR;
`endif
        else               e.kind = EV_READY;
        exp_q.push_back(e);
        RxD = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            wait_clk(BIT_CLK);
        end
`ifdef RX_PARITY_EN
        RxD = (^b) ^ !par_ok;
        wait_clk(BIT_CLK);
`else
        if (par_ok) RxD = 1'b1;   // unused in 8N1 framing
`endif
        RxD = stop_ok;
        wait_clk(BIT_CLK);
        RxD = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 12 * BIT_CLK) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("expected_strobes_seen", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops one expectation per strobe and checks data hold.
    // ------------------------------------------------------------------
    logic [7:0] mon_data = 8'h00;

    initial begin
        ev_t e;
        int  got;
        int  lat;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                mon_data = 8'h00;
            end else if (RxD_data_ready || RxD_frame_err || perr) begin
                chk("single_strobe",
                    32'(RxD_data_ready) + 32'(RxD_frame_err) + 32'(perr), 1);
                got = RxD_data_ready ? EV_READY : (RxD_frame_err ? EV_FERR : EV_PERR);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got kind %0d expected none (cycle %0d)",
                             got, cyc);
                end else begin
                    e   = exp_q.pop_front();
                    lat = cyc - e.t0;
                    chk("strobe_kind", got, e.kind);
                    checks++;
                    if (lat < LAT_MIN || lat > LAT_MAX) begin
                        errors++;
                        $display("FAIL strobe_latency: got %0d clk expected %0d..%0d",
                                 lat, LAT_MIN, LAT_MAX);
                    end
                    if (e.kind == EV_READY) mon_data = e.data;
                    chk("rx_data", RxD_data, mon_data);
                end
            end else if (RxD_data !== mon_data) begin
                checks++;
                errors++;
                $display("FAIL data_hold: got 0x%0h expected 0x%0h (cycle %0d)",
                         RxD_data, mon_data, cyc);
                mon_data = RxD_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] b;
        bit         s_ok;
        bit         p_ok;
        ev_t        e;

        RxD = 1'b1;
        rst = 1'b1;
        wait_clk(3);
        chk("reset_data",  RxD_data, 8'h00);
        chk("reset_ready", RxD_data_ready, 1'b0);
        chk("reset_ferr",  RxD_frame_err, 1'b0);
        chk("reset_busy",  RxD_busy, 1'b0);
        rst = 1'b0;
        wait_clk(20);

        // Single good frame
        send_frame(8'h33, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        drain();
        chk("single_busy", RxD_busy, 1'b0);
        chk("single_data", RxD_data, 8'h33);

        // Back-to-back frames, no idle gap
        send_frame(8'h23, 1'b1, 1'b1);
        send_frame(8'h56, 1'b1, 1'b1);
        send_frame(8'h0D, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        drain();
        chk("b2b_data", RxD_data, 8'h0D);

        // 1 us glitch: busy rises then falls, nothing else
        RxD = 1'b0;
        wait_clk(50);
        RxD = 1'b1;
        chk("glitch_busy_rise", RxD_busy, 1'b1);
        wait_clk(600);
        chk("glitch_busy_fall", RxD_busy, 1'b0);
        chk("glitch_data", RxD_data, 8'h0D);
        wait_clk(BIT_CLK);

        // Stop bit low, then a good frame
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_clk(BIT_CLK);
        chk("ferr_data_kept", RxD_data, 8'h0D);
        send_frame(8'h5A, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        drain();
        chk("after_ferr_data", RxD_data, 8'h5A);

        // Reset pulse during data bit 4 of 0xFF
        RxD = 1'b0;
        wait_clk(BIT_CLK);
        RxD = 1'b1;
        wait_clk(4 * BIT_CLK + BIT_CLK / 2);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        chk("midrst_data",  RxD_data, 8'h00);
        chk("midrst_ready", RxD_data_ready, 1'b0);
        chk("midrst_ferr",  RxD_frame_err, 1'b0);
        chk("midrst_busy",  RxD_busy, 1'b0);
        wait_clk(5 * BIT_CLK);
        send_frame(8'h41, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        drain();
        chk("after_rst_data", RxD_data, 8'h41);

        // Break: exactly one frame error, no restart while the line stays low
        e.kind = EV_FERR;
        e.data = 8'h00;
        e.t0   = cyc;
        exp_q.push_back(e);
        RxD = 1'b0;
        wait_clk(13 * BIT_CLK);
        chk("break_idle", RxD_busy, 1'b0);
        chk("break_one_ferr", exp_q.size(), 0);
        RxD = 1'b1;
        wait_clk(BIT_CLK);
        exp_q.delete();
        chk("break_data_kept", RxD_data, 8'h41);

`ifdef RX_PARITY_EN
        send_frame(8'h33, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        drain();
        chk("parity_ok_data", RxD_data, 8'h33);
        send_frame(8'h33, 1'b1, 1'b0);
        wait_clk(BIT_CLK);
        drain();
        chk("parity_bad_data", RxD_data, 8'h33);
`endif

        // Randomized frames
        for (int i = 0; i < 6; i++) begin
            b    = 8'($urandom);
            s_ok = ($urandom_range(0, 3) != 0);
            p_ok = ($urandom_range(0, 3) != 0);
            send_frame(b, s_ok, p_ok);
            // A low stop bit needs the line back high before the next edge counts.
            wait_clk(s_ok ? $urandom_range(1, 200) : BIT_CLK);
        end
        wait_clk(BIT_CLK);
        drain();
        chk("final_busy", RxD_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
